// File: rtl/fwd_scoreboard_if.sv
// Bundle of issue, load-response, operand-forwarding and writeback signals for fwd_scoreboard.
// The master modport belongs to the decode/issue side. The slave modport belongs to the scoreboard.
interface fwd_scoreboard_if #(
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 3,
   parameter int XLEN    = 32,
   parameter int SW      = $clog2(DEPTH)
);
   // Handshake semantics:
   // - advance qualifies the ins_* fields, which are sampled only when advance is high.
   // - ld_resp_valid is a one-cycle valid with no ready; the scoreboard always accepts it.
   // - Every output is combinational on the current state, except stall_count and err_flags, which are registered.
   logic                    advance;
   logic                    ins_valid;
   logic                    ins_we;
   logic                    ins_is_load;
   logic [4:0]              ins_rd;
   logic [XLEN-1:0]         ins_data;
   logic                    ld_resp_valid;
   logic [XLEN-1:0]         ld_resp_data;
   logic [NUM_SRC*5-1:0]    src_rs;
   logic [NUM_SRC-1:0]      fwd_hit;
   logic [NUM_SRC*XLEN-1:0] fwd_data;
   logic [NUM_SRC*SW-1:0]   fwd_stage;
   logic                    hazard_stall;
   logic                    ld_pending;
   logic                    retire_block;
   logic                    rf_we;
   logic [4:0]              rf_rd;
   logic [XLEN-1:0]         rf_wdata;
   logic [31:0]             stall_count;
   logic [1:0]              err_flags;

   modport master (
      output advance, ins_valid, ins_we, ins_is_load, ins_rd, ins_data,
             ld_resp_valid, ld_resp_data, src_rs,
      input  fwd_hit, fwd_data, fwd_stage, hazard_stall, ld_pending, retire_block,
             rf_we, rf_rd, rf_wdata, stall_count, err_flags
   );

   modport slave (
      input  advance, ins_valid, ins_we, ins_is_load, ins_rd, ins_data,
             ld_resp_valid, ld_resp_data, src_rs,
      output fwd_hit, fwd_data, fwd_stage, hazard_stall, ld_pending, retire_block,
             rf_we, rf_rd, rf_wdata, stall_count, err_flags
   );
endinterface

// File: rtl/fwd_scoreboard.sv
// Shifting in-flight writer scoreboard: youngest-match operand bypass, load-use stall detection,
// and register-file writeback from the oldest entry.
module fwd_scoreboard #(
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 3,
   parameter int XLEN    = 32,
   parameter int SW      = $clog2(DEPTH)
) (
   input logic          clk,
   input logic          rst_n,
   fwd_scoreboard_if.slave bus
);
   typedef struct packed {
      logic            valid;
      logic            we;
      logic            is_load;
      logic            dv;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } entry_t;

   entry_t             ent     [DEPTH];
   entry_t             ent_upd [DEPTH];
   entry_t             ent_nxt [DEPTH];
   logic [DEPTH-1:0]   pend;
   logic               pending_any;
   logic               resp_hit;
   logic [NUM_SRC-1:0] hit;
   logic [NUM_SRC*XLEN-1:0] fdata;
   logic [NUM_SRC*SW-1:0]   fstage;
   logic               stall_any;
   logic [4:0]         rs_v;
   logic               found;
   logic [SW-1:0]      win_idx;
   logic               win_dv;
   logic               win_pend;
   logic [XLEN-1:0]    win_data;
   logic               last_byp;
   logic               last_ready;
   logic [31:0]        stall_cnt;
   logic [1:0]         err_q;

   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         pend[k] = ent[k].valid & ent[k].is_load & ~ent[k].dv;
      end
   end

   assign pending_any = |pend;
   assign resp_hit    = bus.ld_resp_valid & pending_any;

   // Apply the load response before the shift so it lands at the entry's post-shift position.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         ent_upd[k] = ent[k];
         if (resp_hit && pend[k]) begin
            ent_upd[k].dv   = 1'b1;
            ent_upd[k].data = bus.ld_resp_data;
         end
      end
      for (int k = 0; k < DEPTH; k++) begin
         ent_nxt[k] = ent_upd[k];
      end
      if (bus.advance) begin
         for (int k = 1; k < DEPTH; k++) begin
            ent_nxt[k] = ent_upd[k-1];
         end
         ent_nxt[0].valid   = bus.ins_valid;
         ent_nxt[0].we      = bus.ins_we;
         ent_nxt[0].is_load = bus.ins_is_load;
         ent_nxt[0].dv      = ~bus.ins_is_load;
         ent_nxt[0].rd      = bus.ins_rd;
         ent_nxt[0].data    = bus.ins_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            ent[k] <= '0;
         end
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            ent[k] <= ent_nxt[k];
         end
      end
   end

   // Walk from oldest to youngest so the lowest matching index is the last one to be written.
   always_comb begin
      hit       = '0;
      fdata     = '0;
      fstage    = '0;
      stall_any = 1'b0;
      rs_v      = '0;
      found     = 1'b0;
      win_idx   = '0;
      win_dv    = 1'b0;
      win_pend  = 1'b0;
      win_data  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         rs_v     = bus.src_rs[5*i +: 5];
         found    = 1'b0;
         win_idx  = '0;
         win_dv   = 1'b0;
         win_pend = 1'b0;
         win_data = '0;
         for (int k = DEPTH-1; k >= 0; k--) begin
            if (ent[k].valid && ent[k].we && ent[k].rd == rs_v && rs_v != 5'd0) begin
               found    = 1'b1;
               win_idx  = SW'(k);
               win_dv   = ent[k].dv;
               win_pend = pend[k];
               win_data = ent[k].data;
            end
         end
         if (found) begin
            fstage[SW*i +: SW] = win_idx;
            if (win_dv) begin
               hit[i]                 = 1'b1;
               fdata[XLEN*i +: XLEN]  = win_data;
            end else if (win_pend && bus.ld_resp_valid) begin
               hit[i]                 = 1'b1;
               fdata[XLEN*i +: XLEN]  = bus.ld_resp_data;
            end else begin
               stall_any = 1'b1;
            end
         end
      end
   end

   assign last_byp   = pend[DEPTH-1] & bus.ld_resp_valid;
   assign last_ready = ent[DEPTH-1].dv | last_byp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         err_q     <= '0;
      end else begin
         if (stall_any && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         err_q <= err_q | {bus.advance & bus.ins_valid & bus.ins_is_load & pending_any & ~bus.ld_resp_valid,
                           bus.ld_resp_valid & ~pending_any};
      end
   end

   assign bus.fwd_hit      = hit;
   assign bus.fwd_data     = fdata;
   assign bus.fwd_stage    = fstage;
   assign bus.hazard_stall = stall_any;
   assign bus.ld_pending   = pending_any;
   assign bus.retire_block = ent[DEPTH-1].valid & ~last_ready;
   assign bus.rf_we        = bus.advance & ent[DEPTH-1].valid & ent[DEPTH-1].we & last_ready &
                             (ent[DEPTH-1].rd != 5'd0);
   assign bus.rf_rd        = ent[DEPTH-1].valid ? ent[DEPTH-1].rd : 5'd0;
   assign bus.rf_wdata     = !ent[DEPTH-1].valid ? '0 :
                             ent[DEPTH-1].dv ? ent[DEPTH-1].data :
                             last_byp ? bus.ld_resp_data : '0;
   assign bus.stall_count  = stall_cnt;
   assign bus.err_flags    = err_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed scenarios plus random traffic, checked against a
// queue-of-records reference model through an expected-response scoreboard.
module tb_fwd_scoreboard;
   localparam int NUM_SRC = 2;
   localparam int DEPTH   = 3;
   localparam int XLEN    = 32;
   localparam int SW      = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #10 clk = ~clk;

   fwd_scoreboard_if #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .XLEN(XLEN), .SW(SW)) bus ();

   fwd_scoreboard #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .XLEN(XLEN), .SW(SW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      bit          valid;
      bit          we;
      bit          is_load;
      bit          ready;
      logic [4:0]  rd;
      logic [31:0] data;
   } rec_t;

   typedef struct packed {
      logic [1:0]  hit;
      logic [1:0]  data_chk;
      logic [63:0] data;
      logic [3:0]  stage;
      logic        hz;
      logic        lp;
      logic        rb;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic [31:0] sc;
      logic [1:0]  err;
   } exp_t;

   rec_t        pipe[$];
   logic [31:0] m_cnt;
   logic [1:0]  m_err;
   exp_t        exp_q[$];
   int          n_chk  = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      rec_t z;
      z = '{default: '0};
      pipe.delete();
      for (int k = 0; k < DEPTH; k++) pipe.push_back(z);
      m_cnt = '0;
      m_err = '0;
   endfunction

   function automatic int pending_idx();
      for (int k = 0; k < DEPTH; k++) begin
         if (pipe[k].valid && pipe[k].is_load && !pipe[k].ready) return k;
      end
      return -1;
   endfunction

   // Expected outputs for the current cycle, then the model steps to the next cycle.
   function automatic void predict(input bit adv, input bit iv, input bit we, input bit ld,
                                   input logic [4:0] rd, input logic [31:0] d,
                                   input bit lrv, input logic [31:0] lrd,
                                   input logic [4:0] s0, input logic [4:0] s1);
      exp_t       e;
      int         p;
      int         w;
      logic [4:0] s;
      rec_t       last;
      rec_t       n;
      bit         byp;
      e = '0;
      p = pending_idx();
      for (int i = 0; i < 2; i++) begin
         s = (i == 0) ? s0 : s1;
         w = -1;
         for (int k = 0; k < DEPTH; k++) begin
            if (w < 0 && pipe[k].valid && pipe[k].we && pipe[k].rd == s && s != 5'd0) w = k;
         end
         if (w < 0) begin
            e.data_chk[i] = 1'b1;
         end else begin
            e.stage[2*i +: 2] = w[1:0];
            if (pipe[w].ready) begin
               e.hit[i] = 1'b1; e.data_chk[i] = 1'b1; e.data[32*i +: 32] = pipe[w].data;
            end else if (w == p && lrv) begin
               e.hit[i] = 1'b1; e.data_chk[i] = 1'b1; e.data[32*i +: 32] = lrd;
            end else begin
               e.hz = 1'b1;
            end
         end
      end
      e.lp  = (p >= 0);
      last  = pipe[DEPTH-1];
      byp   = (p == DEPTH-1) && lrv;
      e.rb  = last.valid && !last.ready && !byp;
      e.we  = adv && last.valid && last.we && (last.ready || byp) && last.rd != 5'd0;
      e.rd  = last.rd;
      e.wd  = last.ready ? last.data : lrd;
      e.sc  = m_cnt;
      e.err = m_err;
      exp_q.push_back(e);
      if (e.hz && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (lrv && p < 0) m_err[0] = 1'b1;
      if (adv && iv && ld && p >= 0 && !lrv) m_err[1] = 1'b1;
      if (lrv && p >= 0) begin
         n = pipe[p]; n.ready = 1'b1; n.data = lrd; pipe[p] = n;
      end
      if (adv) begin
         n.valid = iv; n.we = we; n.is_load = ld; n.ready = !ld; n.rd = rd; n.data = d;
         pipe.push_front(n);
         void'(pipe.pop_back());
      end
   endfunction

   task automatic set_idle();
      bus.advance = 1'b0; bus.ins_valid = 1'b0; bus.ins_we = 1'b0; bus.ins_is_load = 1'b0;
      bus.ins_rd = '0; bus.ins_data = '0; bus.ld_resp_valid = 1'b0; bus.ld_resp_data = '0;
      bus.src_rs = '0;
   endtask

   task automatic drive(input bit adv, input bit iv, input bit we, input bit ld,
                        input logic [4:0] rd, input logic [31:0] d,
                        input bit lrv, input logic [31:0] lrd,
                        input logic [4:0] s0, input logic [4:0] s1);
      @(negedge clk);
      bus.advance = adv; bus.ins_valid = iv; bus.ins_we = we; bus.ins_is_load = ld;
      bus.ins_rd = rd; bus.ins_data = d; bus.ld_resp_valid = lrv; bus.ld_resp_data = lrd;
      bus.src_rs = {s1, s0};
      #1;
      predict(adv, iv, we, ld, rd, d, lrv, lrd, s0, s1);
   endtask

   task automatic idle(input logic [4:0] s0, input logic [4:0] s1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, s0, s1);
   endtask

   task automatic bubble();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd0, 5'd0);
   endtask

   // Monitor: compares the DUT against the oldest expected response, mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("fwd_hit", bus.fwd_hit, e.hit);
            for (int i = 0; i < NUM_SRC; i++) begin
               chk("fwd_stage", bus.fwd_stage[SW*i +: SW], e.stage[2*i +: 2]);
               if (e.data_chk[i]) chk("fwd_data", bus.fwd_data[XLEN*i +: XLEN], e.data[32*i +: 32]);
            end
            chk("hazard_stall", bus.hazard_stall, e.hz);
            chk("ld_pending", bus.ld_pending, e.lp);
            chk("retire_block", bus.retire_block, e.rb);
            chk("rf_we", bus.rf_we, e.we);
            if (e.we) begin
               chk("rf_rd", bus.rf_rd, e.rd);
               chk("rf_wdata", bus.rf_wdata, e.wd);
            end
            chk("stall_count", bus.stall_count, e.sc);
            chk("err_flags", bus.err_flags, e.err);
         end
      end
   end

   initial begin
      logic [4:0]  r_rd, r_s0, r_s1;
      logic [31:0] r_d, r_lrd;
      bit          r_adv, r_iv, r_we, r_ld, r_lrv;

      set_idle();
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      idle(5'd0, 5'd0);
      #2;
      chk("reset_fwd_hit", bus.fwd_hit, 2'b00);
      chk("reset_stall_count", bus.stall_count, 32'd0);
      chk("reset_err_flags", bus.err_flags, 2'b00);

      // Back-to-back ALU chain: youngest x5 wins
      drive(1, 1, 1, 0, 5'd5, 32'h11, 0, 0, 0, 0);
      drive(1, 1, 1, 0, 5'd5, 32'h22, 0, 0, 0, 0);
      idle(5'd5, 5'd0);
      #2;
      chk("alu_hit", bus.fwd_hit[0], 1'b1);
      chk("alu_data", bus.fwd_data[31:0], 32'h22);
      chk("alu_stage", bus.fwd_stage[1:0], 2'd0);
      repeat (DEPTH) bubble();

      // Load-use stall, then transparent bypass of the response
      drive(1, 1, 1, 1, 5'd7, 32'h0, 0, 0, 0, 0);
      repeat (3) begin
         idle(5'd0, 5'd7);
         #2;
         chk("ldu_stall", bus.hazard_stall, 1'b1);
         chk("ldu_hit", bus.fwd_hit[1], 1'b0);
      end
      drive(0, 0, 0, 0, 5'd0, 32'd0, 1, 32'hDEAD, 5'd0, 5'd7);
      #2;
      chk("ldu_stall_count", bus.stall_count, 32'd3);
      chk("ldu_bypass_hit", bus.fwd_hit[1], 1'b1);
      chk("ldu_bypass_data", bus.fwd_data[63:32], 32'hDEAD);
      idle(5'd0, 5'd7);
      #2;
      chk("ldu_after_stall", bus.hazard_stall, 1'b0);
      chk("ldu_after_data", bus.fwd_data[63:32], 32'hDEAD);
      repeat (DEPTH) bubble();

      // x0 never forwards and never writes back
      drive(1, 1, 1, 0, 5'd0, 32'h55, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 5'd0);
      #2;
      chk("x0_hit", bus.fwd_hit, 2'b00);
      bubble();
      bubble();
      #2;
      chk("x0_rf_we", bus.rf_we, 1'b0);

      // Writeback of x3 only on the third advance
      drive(1, 1, 1, 0, 5'd3, 32'h9, 0, 0, 0, 0);
      bubble(); #2; chk("wb_adv1", bus.rf_we, 1'b0);
      bubble(); #2; chk("wb_adv2", bus.rf_we, 1'b0);
      bubble(); #2;
      chk("wb_adv3_we", bus.rf_we, 1'b1);
      chk("wb_adv3_rd", bus.rf_rd, 5'd3);
      chk("wb_adv3_data", bus.rf_wdata, 32'h9);

      // Load reaching the oldest entry blocks retirement until its data returns
      drive(1, 1, 1, 1, 5'd4, 32'h0, 0, 0, 0, 0);
      bubble();
      bubble();
      idle(5'd0, 5'd0);
      #2;
      chk("retire_block", bus.retire_block, 1'b1);
      drive(1, 0, 0, 0, 5'd0, 32'd0, 1, 32'h44, 5'd0, 5'd0);
      #2;
      chk("retire_byp_we", bus.rf_we, 1'b1);
      chk("retire_byp_data", bus.rf_wdata, 32'h44);

      // Spurious response with nothing pending
      drive(0, 0, 0, 0, 5'd0, 32'd0, 1, 32'h1, 5'd0, 5'd0);
      idle(5'd0, 5'd0);
      #2;
      chk("err_spurious", bus.err_flags, 2'b01);

      // Second load while one is pending, then reset in the middle of the stall
      drive(1, 1, 1, 1, 5'd8, 32'h0, 0, 0, 0, 0);
      drive(1, 1, 1, 1, 5'd9, 32'h0, 0, 0, 0, 0);
      idle(5'd0, 5'd9);
      #2;
      chk("err_second_load", bus.err_flags, 2'b11);
      chk("stall_before_reset", bus.hazard_stall, 1'b1);
      #2;
      rst_n = 1'b0;
      set_idle();
      bus.src_rs = {5'd9, 5'd9};
      #1;
      chk("async_rst_stall", bus.hazard_stall, 1'b0);
      chk("async_rst_pending", bus.ld_pending, 1'b0);
      chk("async_rst_hit", bus.fwd_hit, 2'b00);
      chk("async_rst_count", bus.stall_count, 32'd0);
      chk("async_rst_err", bus.err_flags, 2'b00);
      chk("async_rst_block", bus.retire_block, 1'b0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(5'd9, 5'd9);
      #2;
      chk("post_rst_hit", bus.fwd_hit, 2'b00);

      // Random traffic, keeping at most one outstanding load
      for (int c = 0; c < 600; c++) begin
         r_adv = ($urandom_range(0, 9) < 7);
         r_iv  = ($urandom_range(0, 9) < 8);
         r_we  = ($urandom_range(0, 9) < 8);
         r_ld  = (pending_idx() < 0) && ($urandom_range(0, 9) < 3);
         r_rd  = 5'($urandom_range(0, 7));
         r_d   = $urandom;
         r_lrv = (pending_idx() >= 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 39) == 0);
         r_lrd = $urandom;
         r_s0  = 5'($urandom_range(0, 7));
         r_s1  = 5'($urandom_range(0, 7));
         drive(r_adv, r_iv, r_we, r_ld, r_rd, r_d, r_lrv, r_lrd, r_s0, r_s1);
      end

      repeat (3) @(negedge clk);
      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
